// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, requester ids and size constants shared by the memory arbiter.
package mem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t RESP   = 2'd3;
  localparam logic CPU = 1'b0;
  localparam logic LDR = 1'b1;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_CNT_W  = 3;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the requester not granted last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o,
  output logic       valid_o
);
  assign valid_o = |req_i;
  assign win_o   = &req_i ? ~last_i : req_i[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU and the loader, one access at a time.
// Define MEM_ARB_LOCK_EN to add ldr_lock, which keeps the memory with the loader for bursts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LAT = RD_LAT < RD_LAT_MIN ? RD_LAT_MIN : RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : RD_LAT;
  state_t               state_q, state_d;
  logic                 last_q, last_d, we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d, ldr_rdata_q, ldr_rdata_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           req;
  logic                 win, pick;
`ifdef MEM_ARB_LOCK_EN
  // a locked loader that owned the last grant hides the CPU request entirely
  assign req = {ldr_req, cpu_req & ~(ldr_lock & (last_q == LDR))};
`else
  assign req = {ldr_req, cpu_req};
`endif
  rr_pick2 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (win),
    .valid_o(pick)
  );
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: if (pick) begin
        state_d = ACCESS;
        last_d  = win;
        we_d    = win ? ldr_we : cpu_we;
        addr_d  = win ? ldr_addr : cpu_addr;
        wdata_d = win ? ldr_wdata : cpu_wdata;
      end
      ACCESS: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = LAT_CNT_W'(LAT - 1);
      end
      WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        state_d = RESP;
        if (last_q == LDR) ldr_rdata_d = mem_rdata;
        else cpu_rdata_d = mem_rdata;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= LDR;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end
  assign cpu_gnt    = state_q == ACCESS && last_q == CPU;
  assign ldr_gnt    = state_q == ACCESS && last_q == LDR;
  assign cpu_rvalid = state_q == RESP && last_q == CPU;
  assign ldr_rvalid = state_q == RESP && last_q == LDR;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_rd     = state_q == ACCESS && !we_q;
  assign mem_wr     = state_q == ACCESS && we_q;
  assign busy       = state_q != IDLE;
endmodule
